// File: rtl/mux_bin_pkg.sv
// Tree-shape helpers for the pipelined binary-select mux: level count, select bits and entries per level.
package mux_bin_pkg;

  function automatic int levels(int width, int split);
    int wl;
    int sl;
    wl = $clog2(width);
    sl = $clog2(split);
    return (wl + sl - 1) / sl;
  endfunction

  // The last level takes whatever select bits remain, which may be fewer than a full level.
  function automatic int level_bits(int width, int split, int k);
    int sl;
    int nl;
    sl = $clog2(split);
    nl = levels(width, split);
    if (k < nl - 1) return sl;
    return $clog2(width) - (nl - 1) * sl;
  endfunction

  function automatic int level_width(int width, int split, int k);
    int used;
    used = 0;
    for (int i = 0; i <= k; i++) used += level_bits(width, split, i);
    return width >> used;
  endfunction

endpackage

// File: rtl/mux_bin.sv
// Combinational binary-select mux: dat = ary[bin].
// Zero latency, no flow control.
module mux_bin #(
  parameter type DAT_T = logic [7:0],
  parameter int  WIDTH = 4
) (
  input  logic [$clog2(WIDTH)-1:0] bin,
  input  DAT_T [WIDTH-1:0]         ary,
  output DAT_T                     dat
);

  assign dat = ary[bin];

endmodule

// File: rtl/mux_bin_pipe_stage.sv
// One registered mux-tree level: groups of N entries reduced by the low select bits.
// One cycle latency; stage loads whenever it is empty or downstream is ready.
module mux_bin_pipe_stage
  import mux_bin_pkg::*;
#(
  parameter type DAT_T = logic [7:0],
  parameter int  IN_W  = 16,
  parameter int  LB    = 2,
  parameter int  SEL_W = 4,
  localparam int N     = 1 << LB,
  localparam int OUT_W = IN_W / N,
  localparam int SO_W  = (SEL_W > LB) ? SEL_W - LB : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_vld,
  output logic              up_rdy,
  input  DAT_T [IN_W-1:0]   up_ary,
  input  logic [SEL_W-1:0]  up_sel,
  output logic              vld_o,
  input  logic              dn_rdy,
  output DAT_T [OUT_W-1:0]  ary_o,
  output logic [SO_W-1:0]   sel_o
);

  DAT_T [OUT_W-1:0] ary_mux, ary_d, ary_q;
  logic [SO_W-1:0]  sel_rem, sel_d, sel_q;
  logic             vld_d, vld_q;

  for (genvar g = 0; g < OUT_W; g++) begin : g_grp
    mux_bin #(.DAT_T(DAT_T), .WIDTH(N)) u_mux (
      .bin (up_sel[LB-1:0]),
      .ary (up_ary[g*N +: N]),
      .dat (ary_mux[g])
    );
  end

  // The final level has no select bits left to forward.
  if (SEL_W > LB) begin : g_sel
    assign sel_rem = up_sel[SEL_W-1:LB];
  end else begin : g_nosel
    assign sel_rem = '0;
  end

  assign up_rdy = ~vld_q | dn_rdy;

  always_comb begin
    vld_d = up_rdy ? up_vld : vld_q;
    ary_d = ary_q;
    sel_d = sel_q;
    if (up_rdy && up_vld) begin
      ary_d = ary_mux;
      sel_d = sel_rem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
    ary_q <= ary_d;
    sel_q <= sel_d;
  end

  assign vld_o = vld_q;
  assign ary_o = ary_q;
  assign sel_o = sel_q;

endmodule

// File: rtl/mux_bin_pipe.sv
// Pipelined ary[bin] select, LEVELS-cycle latency, valid/ready with bubble collapse.
// MUX_BIN_PIPE_SKID_EN adds a 2-entry skid buffer so i_rdy comes straight from a flop.
module mux_bin_pipe
  import mux_bin_pkg::*;
#(
  parameter type DAT_T     = logic [8-1:0],
  parameter int  WIDTH     = 16,
  parameter int  SPLIT     = 4,
  localparam int WIDTH_LOG = $clog2(WIDTH),
  localparam int SPLIT_LOG = $clog2(SPLIT),
  localparam int LEVELS    = levels(WIDTH, SPLIT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  output logic                 i_rdy,
  input  logic [WIDTH_LOG-1:0] bin,
  input  DAT_T [WIDTH-1:0]     ary,
  output logic                 o_vld,
  input  logic                 o_rdy,
  output DAT_T                 dat
);

  logic [LEVELS:0]      rdy;
  logic [LEVELS-1:0]    vld;
  logic                 s0_vld;
  DAT_T [WIDTH-1:0]     s0_ary;
  logic [WIDTH_LOG-1:0] s0_sel;
  logic                 sel_unused;

`ifdef MUX_BIN_PIPE_SKID_EN
  typedef struct packed {
    logic [WIDTH_LOG-1:0] sel;
    DAT_T [WIDTH-1:0]     ary;
  } ent_t;

  ent_t       in_ent, sk0_d, sk0_q, sk1_d, sk1_q;
  logic [1:0] cnt_d, cnt_q;
  logic       rdy_d, rdy_q;
  logic       in_xfer;

  assign in_ent  = '{sel: bin, ary: ary};
  assign in_xfer = i_vld & rdy_q;
  assign i_rdy   = rdy_q;
  // An empty buffer is bypassed so unstalled latency stays at LEVELS.
  assign s0_vld  = (cnt_q != 2'd0) | i_vld;
  assign s0_ary  = (cnt_q != 2'd0) ? sk0_q.ary : ary;
  assign s0_sel  = (cnt_q != 2'd0) ? sk0_q.sel : bin;

  always_comb begin
    cnt_d = cnt_q;
    sk0_d = sk0_q;
    sk1_d = sk1_q;
    case (cnt_q)
      2'd0: begin
        if (in_xfer && !rdy[0]) begin
          sk0_d = in_ent;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (rdy[0]) begin
          if (in_xfer) sk0_d = in_ent;
          else         cnt_d = 2'd0;
        end else if (in_xfer) begin
          sk1_d = in_ent;
          cnt_d = 2'd2;
        end
      end
      default: begin
        if (rdy[0]) begin
          sk0_d = sk1_q;
          cnt_d = 2'd1;
        end
      end
    endcase
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
    sk0_q <= sk0_d;
    sk1_q <= sk1_d;
  end
`else
  assign i_rdy  = rdy[0];
  assign s0_vld = i_vld;
  assign s0_ary = ary;
  assign s0_sel = bin;
`endif

  assign rdy[LEVELS] = o_rdy;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int IN_W  = (k == 0) ? WIDTH : level_width(WIDTH, SPLIT, k - 1);
    localparam int OUT_W = level_width(WIDTH, SPLIT, k);
    localparam int LB    = level_bits(WIDTH, SPLIT, k);
    localparam int SEL_W = WIDTH_LOG - k * SPLIT_LOG;
    localparam int SO_W  = (SEL_W > LB) ? SEL_W - LB : 1;

    logic             up_vld;
    DAT_T [IN_W-1:0]  up_ary;
    logic [SEL_W-1:0] up_sel;
    DAT_T [OUT_W-1:0] ary_q;
    logic [SO_W-1:0]  sel_q;

    if (k == 0) begin : g_head
      assign up_vld = s0_vld;
      assign up_ary = s0_ary;
      assign up_sel = s0_sel;
    end else begin : g_body
      assign up_vld = vld[k-1];
      assign up_ary = g_lvl[k-1].ary_q;
      assign up_sel = g_lvl[k-1].sel_q;
    end

    mux_bin_pipe_stage #(
      .DAT_T (DAT_T),
      .IN_W  (IN_W),
      .LB    (LB),
      .SEL_W (SEL_W)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .up_vld (up_vld),
      .up_rdy (rdy[k]),
      .up_ary (up_ary),
      .up_sel (up_sel),
      .vld_o  (vld[k]),
      .dn_rdy (rdy[k+1]),
      .ary_o  (ary_q),
      .sel_o  (sel_q)
    );
  end

  assign o_vld      = vld[LEVELS-1];
  assign dat        = g_lvl[LEVELS-1].ary_q[0];
  assign sel_unused = ^g_lvl[LEVELS-1].sel_q;

endmodule

// File: tb/tb_mux_bin_pipe.sv
// Scoreboard bench for mux_bin_pipe: 16/4 tree for flow-control scenarios, 8/4 tree for the uneven last level.
module tb_mux_bin_pipe;

  localparam int LAT = 2;
`ifdef MUX_BIN_PIPE_SKID_EN
  localparam int CAP = LAT + 2;
`else
  localparam int CAP = LAT;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_vld = 1'b0;
  logic            i_rdy;
  logic [3:0]      bin = '0;
  logic [15:0][7:0] ary = '0;
  logic            o_vld;
  logic            o_rdy = 1'b0;
  logic [7:0]      dat;

  logic            i_vld8 = 1'b0;
  logic            i_rdy8;
  logic [2:0]      bin8 = '0;
  logic [7:0][7:0] ary8 = '0;
  logic            o_vld8;
  logic            o_rdy8 = 1'b1;
  logic [7:0]      dat8;

  int         vec = 0;
  int         errs = 0;
  int         cyc = 0;
  bit         chk_lat = 1'b0;
  logic [7:0] exp_q[$];
  int         acc_q[$];

  always #5 clk = ~clk;

  mux_bin_pipe #(.DAT_T(logic [7:0]), .WIDTH(16), .SPLIT(4)) u_dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(i_rdy), .bin(bin), .ary(ary),
    .o_vld(o_vld), .o_rdy(o_rdy), .dat(dat)
  );

  mux_bin_pipe #(.DAT_T(logic [7:0]), .WIDTH(8), .SPLIT(4)) u_dut8 (
    .clk(clk), .rst(rst), .i_vld(i_vld8), .i_rdy(i_rdy8), .bin(bin8), .ary(ary8),
    .o_vld(o_vld8), .o_rdy(o_rdy8), .dat(dat8)
  );

  task automatic monitor();
    logic [7:0] e;
    int         a;
    forever begin
      @(negedge clk);
      if (o_vld === 1'b1 && o_rdy === 1'b1) begin
        vec++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_output: dat=%0d appeared, required no output", dat);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          if (dat !== e) begin
            errs++;
            $display("FAIL out_data: dat=%0d, required %0d", dat, e);
          end
          if (chk_lat) begin
            vec++;
            if (cyc - a != LAT) begin
              errs++;
              $display("FAIL latency: %0d cycles, required %0d", cyc - a, LAT);
            end
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] b);
    bit done;
    done  = 1'b0;
    i_vld = 1'b1;
    bin   = b;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (i_rdy === 1'b1) begin
        exp_q.push_back(ary[b]);
        acc_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    i_vld = 1'b0;
    if (!done) begin
      vec++;
      errs++;
      $display("FAIL send_timeout: bin=%0d not accepted in 200 cycles, required acceptance", b);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    @(posedge clk);
    #1;
    vec++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d items still pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    i_vld = 1'b1;
    bin   = 4'd5;
    o_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        rst   = 1'b0;
        i_vld = 1'b0;
        o_rdy = 1'b1;
      end
      @(negedge clk);
      vec++;
      if (o_vld !== 1'b0) begin
        errs++;
        $display("FAIL reset_o_vld: o_vld=%b at step %0d, required 0", o_vld, i);
      end
      if (i < 2) begin
        vec++;
        if (i_rdy !== 1'b1) begin
          errs++;
          $display("FAIL reset_i_rdy: i_rdy=%b at step %0d, required 1", i_rdy, i);
        end
      end
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) ary[i] = 8'(i);
    o_rdy   = 1'b1;
    chk_lat = 1'b1;
    for (int b = 0; b < 16; b++) send(4'(b));
    drain();
    chk_lat = 1'b0;
  endtask

  task automatic test_backpressure();
    o_rdy = 1'b0;
    fork
      begin
        send(4'd3);
        send(4'd7);
        send(4'd11);
        send(4'd15);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        vec++;
        if (i_rdy !== 1'b0) begin
          errs++;
          $display("FAIL bp_i_rdy: i_rdy=%b with pipeline full, required 0", i_rdy);
        end
        vec++;
        if (o_vld !== 1'b1 || dat !== 8'd3) begin
          errs++;
          $display("FAIL bp_hold: o_vld=%b dat=%0d, required o_vld=1 dat=3", o_vld, dat);
        end
        @(posedge clk);
        #1;
        o_rdy = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_bubble();
    int c0;
    o_rdy = 1'b0;
    send(4'd9);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vec++;
    if (o_vld !== 1'b1 || dat !== 8'd9) begin
      errs++;
      $display("FAIL bubble_head: o_vld=%b dat=%0d, required o_vld=1 dat=9", o_vld, dat);
    end
    @(posedge clk);
    #1;
    c0 = cyc;
    send(4'd4);
    vec++;
    if (cyc - c0 != 1) begin
      errs++;
      $display("FAIL bubble_accept: accepted after %0d cycles, required 1", cyc - c0);
    end
    @(negedge clk);
    vec++;
    if (o_vld !== 1'b1 || dat !== 8'd9) begin
      errs++;
      $display("FAIL bubble_stall: o_vld=%b dat=%0d, required o_vld=1 dat=9", o_vld, dat);
    end
    @(posedge clk);
    #1;
    o_rdy = 1'b1;
    @(negedge clk);
    vec++;
    if (o_vld !== 1'b1 || dat !== 8'd9) begin
      errs++;
      $display("FAIL bubble_rel0: o_vld=%b dat=%0d, required o_vld=1 dat=9", o_vld, dat);
    end
    @(negedge clk);
    vec++;
    if (o_vld !== 1'b1 || dat !== 8'd4) begin
      errs++;
      $display("FAIL bubble_rel1: o_vld=%b dat=%0d, required o_vld=1 dat=4", o_vld, dat);
    end
    drain();
  endtask

  task automatic test_nonuniform();
    logic [2:0] nb [4] = '{3'd5, 3'd6, 3'd0, 3'd7};
    for (int i = 0; i < 8; i++) ary8[i] = 8'(i);
    for (int j = 0; j < 4; j++) begin
      i_vld8 = 1'b1;
      bin8   = nb[j];
      @(negedge clk);
      vec++;
      if (i_rdy8 !== 1'b1) begin
        errs++;
        $display("FAIL nu_i_rdy: i_rdy=%b, required 1", i_rdy8);
      end
      @(posedge clk);
      #1;
      i_vld8 = 1'b0;
      @(negedge clk);
      vec++;
      if (o_vld8 !== 1'b0) begin
        errs++;
        $display("FAIL nu_early: o_vld=%b one cycle after transfer, required 0", o_vld8);
      end
      @(negedge clk);
      vec++;
      if (o_vld8 !== 1'b1 || dat8 !== 8'(nb[j])) begin
        errs++;
        $display("FAIL nu_data: o_vld=%b dat=%0d, required o_vld=1 dat=%0d", o_vld8, dat8, nb[j]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) ary[i] = 8'(i);
    o_rdy = 1'b0;
    for (int i = 0; i < CAP; i++) send(4'(i + 1));
    @(negedge clk);
    vec++;
    if (i_rdy !== 1'b0) begin
      errs++;
      $display("FAIL capacity: i_rdy=%b after %0d items, required 0", i_rdy, CAP);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    o_rdy = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    vec++;
    if (o_vld !== 1'b0 || i_rdy !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset: o_vld=%b i_rdy=%b, required o_vld=0 i_rdy=1", o_vld, i_rdy);
    end
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send(4'd2);
    drain();
    chk_lat = 1'b0;
  endtask

  task automatic test_random();
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          for (int i = 0; i < 16; i++) ary[i] = 8'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(4'($urandom));
        end
      end
      begin
        for (int n = 0; n < 80; n++) begin
          o_rdy = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        o_rdy = 1'b1;
      end
    join
    o_rdy = 1'b1;
    drain();
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      monitor();
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_nonuniform();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
